// File: rtl/imm_extend_pipe_if.sv
// Producer/consumer handshake bundle for the immediate-extension unit.
// slave is the unit's view; master is the producer-plus-consumer view driving it.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  imm_in;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] imm_out;

  modport master (
    output in_valid, imm_in, mode, out_ready,
    input  in_ready, out_valid, imm_out
  );

  modport slave (
    input  in_valid, imm_in, mode, out_ready,
    output in_ready, out_valid, imm_out
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Immediate extension (zero/sign/sign<<2/rotated-8) into a 2-entry output FIFO; 1-cycle latency.
// Backpressure: in_ready drops when both entries are full, independent of out_ready.
module imm_extend_pipe #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 32
) (
  input logic              clk,
  input logic              reset,
  input logic              flush,
  imm_extend_pipe_if.slave bus
);

  if (IN_W < 8 || IN_W > 24 || OUT_W < IN_W + 2) begin : g_bad_params
    $error("imm_extend_pipe: illegal IN_W/OUT_W combination");
  end

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                              input logic [1:0]      md);
    logic [11:0]      low12;
    logic [OUT_W-1:0] zx;
    logic [OUT_W-1:0] sx;
    logic [OUT_W-1:0] rv;
    logic [OUT_W-1:0] rr;
    int               rot;
    // Size cast keeps the [11:8] rotate field in range even for narrow IN_W.
    low12 = 12'(imm);
    zx    = {{(OUT_W-IN_W){1'b0}}, imm};
    sx    = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    rv    = {{(OUT_W-8){1'b0}}, low12[7:0]};
    rot   = (2 * int'(low12[11:8])) % OUT_W;
    rr    = (rv >> rot) | (rv << (OUT_W - rot));
    case (md)
      2'b00:   extend = zx;
      2'b01:   extend = sx;
      2'b10:   extend = sx << 2;
      default: extend = (IN_W >= 12) ? rr : zx;
    endcase
  endfunction

  logic [OUT_W-1:0] mem [2];
  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic             live;
  logic             push;
  logic             pop;
  logic             out_vld_int;
  logic             in_rdy_int;
  logic [OUT_W-1:0] ext_val;

  // live holds in_ready low until the first edge after reset release.
  assign in_rdy_int  = live && (count != 2'd2);
  assign out_vld_int = (count != 2'd0);
  assign push        = bus.in_valid && in_rdy_int;
  assign pop         = out_vld_int && bus.out_ready;
  assign ext_val     = extend(bus.imm_in, bus.mode);

  assign bus.in_ready  = in_rdy_int;
  assign bus.out_valid = out_vld_int;
  assign bus.imm_out   = out_vld_int ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      live   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      live <= 1'b1;
      if (flush) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= ext_val;
          wr_ptr      <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomized plus directed bench for imm_extend_pipe against a queue-based reference.
module tb_imm_extend_pipe;

  logic clk;
  logic rst;
  logic flush;

  imm_extend_pipe_if #(.IN_W(12), .OUT_W(32)) b12 ();
  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) b16 ();

  imm_extend_pipe #(.IN_W(12), .OUT_W(32)) dut12 (
    .clk(clk), .reset(rst), .flush(flush), .bus(b12)
  );
  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut16 (
    .clk(clk), .reset(rst), .flush(flush), .bus(b16)
  );

  int vectors = 0;
  int errs    = 0;

  logic [31:0] mq[$];
  logic [31:0] popped[$];
  bit          m_live = 1'b0;
  bit          m_push;
  bit          m_pop;

  logic [11:0] sw_imm [5] = '{12'hFFF, 12'hFFF, 12'h800, 12'h4FF, 12'h1FF};
  logic [1:0]  sw_mode[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
  logic [31:0] sw_exp [5] = '{32'h00000FFF, 32'hFFFFFFFF, 32'hFFFFE000,
                              32'hFF000000, 32'hC000003F};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: arithmetic on plain integers, not bit slicing.
  function automatic logic [31:0] ext_model(input logic [31:0] imm, input logic [1:0] m,
                                            input int in_w);
    longint u;
    longint s;
    longint v;
    int     r;
    u = longint'(imm) & ((longint'(1) << in_w) - 1);
    s = (u >= (longint'(1) << (in_w - 1))) ? u - (longint'(1) << in_w) : u;
    case (m)
      2'd0: return 32'(u);
      2'd1: return 32'(s);
      2'd2: return 32'(s * 4);
      default: begin
        if (in_w < 12) return 32'(u);
        v = u % 256;
        r = 2 * int'((u / 256) % 16);
        return 32'(((v << 32) | v) >> r);
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_live = 1'b0;
    end else begin
      if (flush) begin
        mq.delete();
      end else begin
        m_push = b12.in_valid && m_live && (mq.size() < 2);
        m_pop  = b12.out_ready && (mq.size() != 0);
        if (m_pop) popped.push_back(mq.pop_front());
        if (m_push) mq.push_back(ext_model(32'(b12.imm_in), b12.mode, 12));
      end
      m_live = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("out_valid", 32'(b12.out_valid), 32'(mq.size() != 0));
    check("imm_out", b12.imm_out, (mq.size() != 0) ? mq[0] : 32'd0);
    check("in_ready", 32'(b12.in_ready), 32'(m_live && (mq.size() < 2)));
  end

  task automatic drv(input logic v, input logic [11:0] imm, input logic [1:0] m,
                     input logic ordy);
    b12.in_valid  = v;
    b12.imm_in    = imm;
    b12.mode      = m;
    b12.out_ready = ordy;
  endtask

  initial begin
    flush = 1'b0;
    rst   = 1'b0;
    drv(1'b0, 12'h0, 2'd0, 1'b0);
    b16.in_valid  = 1'b0;
    b16.imm_in    = 16'h0;
    b16.mode      = 2'd0;
    b16.out_ready = 1'b0;
    #2 rst = 1'b1;

    check("pin_m00", ext_model(32'hFFF, 2'd0, 12), 32'h00000FFF);
    check("pin_m01", ext_model(32'hFFF, 2'd1, 12), 32'hFFFFFFFF);
    check("pin_m10", ext_model(32'h800, 2'd2, 12), 32'hFFFFE000);
    check("pin_m11a", ext_model(32'h4FF, 2'd3, 12), 32'hFF000000);
    check("pin_m11b", ext_model(32'h1FF, 2'd3, 12), 32'hC000003F);
    check("pin_w16s", ext_model(32'h8000, 2'd1, 16), 32'hFFFF8000);
    check("pin_w16sh", ext_model(32'h8000, 2'd2, 16), 32'hFFFE0000);

    repeat (2) @(negedge clk);
    check("rst_valid12", 32'(b12.out_valid), 32'd0);
    check("rst_imm12", b12.imm_out, 32'd0);
    check("rst_ready12", 32'(b12.in_ready), 32'd0);
    check("rst_valid16", 32'(b16.out_valid), 32'd0);
    check("rst_ready16", 32'(b16.in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready12", 32'(b12.in_ready), 32'd1);
    check("post_rst_ready16", 32'(b16.in_ready), 32'd1);

    // 16-bit variant
    b16.in_valid = 1'b1; b16.imm_in = 16'h8000; b16.mode = 2'd1; b16.out_ready = 1'b1;
    @(negedge clk);
    check("w16_sext_vld", 32'(b16.out_valid), 32'd1);
    check("w16_sext", b16.imm_out, 32'hFFFF8000);
    b16.mode = 2'd2;
    @(negedge clk);
    check("w16_shift", b16.imm_out, 32'hFFFE0000);
    b16.in_valid = 1'b0;
    @(negedge clk);
    check("w16_drain", 32'(b16.out_valid), 32'd0);

    // mode sweep, one push per cycle
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, sw_imm[i], sw_mode[i], 1'b1);
      @(negedge clk);
      check($sformatf("sweep%0d", i), b12.imm_out, sw_exp[i]);
    end
    drv(1'b0, 12'h0, 2'd0, 1'b1);
    @(negedge clk);

    // backpressure
    popped.delete();
    drv(1'b1, 12'h001, 2'd0, 1'b0);
    @(negedge clk);
    drv(1'b1, 12'h002, 2'd0, 1'b0);
    @(negedge clk);
    check("bp_full", 32'(b12.in_ready), 32'd0);
    drv(1'b1, 12'h003, 2'd0, 1'b0);
    @(negedge clk);
    check("bp_hold", 32'(b12.in_ready), 32'd0);
    check("bp_head", b12.imm_out, 32'h1);
    drv(1'b1, 12'h003, 2'd0, 1'b1);
    @(negedge clk);
    check("bp_reopen", 32'(b12.in_ready), 32'd1);
    @(negedge clk);
    drv(1'b0, 12'h0, 2'd0, 1'b1);
    @(negedge clk);
    check("bp_count", popped.size(), 32'd3);
    for (int i = 0; i < 3 && i < popped.size(); i++)
      check($sformatf("bp_order%0d", i), popped[i], 32'(i + 1));

    // sustained push+pop at count 1
    popped.delete();
    drv(1'b1, 12'h100, 2'd0, 1'b1);
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      drv(1'b1, 12'(12'h100 + k), 2'd0, 1'b1);
      @(negedge clk);
      check($sformatf("pp_head%0d", k), b12.imm_out, 32'(32'h100 + k));
    end
    drv(1'b0, 12'h0, 2'd0, 1'b1);
    @(negedge clk);
    check("pp_total", popped.size(), 32'd11);

    // flush at count 2 with input pending
    drv(1'b1, 12'h0A1, 2'd0, 1'b0);
    @(negedge clk);
    drv(1'b1, 12'h0A2, 2'd0, 1'b0);
    @(negedge clk);
    drv(1'b1, 12'h0A3, 2'd0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drv(1'b0, 12'h0, 2'd0, 1'b0);
    check("fl_valid", 32'(b12.out_valid), 32'd0);
    check("fl_imm", b12.imm_out, 32'd0);
    check("fl_ready", 32'(b12.in_ready), 32'd1);
    // flush at count 1 with a real concurrent push and pop
    drv(1'b1, 12'h0B1, 2'd0, 1'b0);
    @(negedge clk);
    drv(1'b1, 12'h0B2, 2'd0, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drv(1'b0, 12'h0, 2'd0, 1'b1);
    @(negedge clk);
    check("fl_push_lost", 32'(b12.out_valid), 32'd0);

    // randomized traffic, holding data while stalled
    for (int n = 0; n < 3000; n++) begin
      if (!(b12.in_valid && !(m_live && mq.size() < 2))) begin
        b12.in_valid = ($urandom_range(0, 3) != 0);
        b12.imm_in   = 12'($urandom);
        b12.mode     = 2'($urandom);
      end
      b12.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 31) == 0);
      @(negedge clk);
    end
    flush = 1'b0;
    drv(1'b0, 12'h0, 2'd0, 1'b1);
    repeat (3) @(negedge clk);

    // async reset with two entries buffered
    drv(1'b1, 12'h0C1, 2'd0, 1'b0);
    @(negedge clk);
    drv(1'b1, 12'h0C2, 2'd0, 1'b0);
    @(negedge clk);
    drv(1'b0, 12'h0, 2'd0, 1'b0);
    check("ar_full", 32'(b12.out_valid), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 32'(b12.out_valid), 32'd0);
    check("ar_imm", b12.imm_out, 32'd0);
    check("ar_ready", 32'(b12.in_ready), 32'd0);
    @(negedge clk);
    check("ar_ready_held", 32'(b12.in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    drv(1'b1, 12'h7FF, 2'd1, 1'b1);
    @(negedge clk);
    check("ar_after", b12.imm_out, 32'h000007FF);
    drv(1'b0, 12'h0, 2'd0, 1'b1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
